// File: rtl/mux_rr_sel.sv
// rtl/mux_rr_sel.sv - N-channel registered selector, fixed-select or round-robin grant (optional MUX_STATS_EN transfer counter)
module mux_rr_sel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [CHANNELS*WIDTH-1:0] i_in,
    input  logic [CHANNELS-1:0]       i_in_valid,
    output logic [CHANNELS-1:0]       o_in_ready,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_selector,
    output logic [WIDTH-1:0]          o_y,
    output logic                      o_y_valid,
    input  logic                      i_y_ready,
    output logic [SEL_W-1:0]          o_y_channel
`ifdef MUX_STATS_EN
    ,
    output logic [15:0]               o_transfer_count
`endif
);

    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_y_channel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load;
    logic             w_fix_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_gnt;
    logic [SEL_W-1:0] w_gnt;
    logic             w_gnt_valid;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;
    logic [SEL_W-1:0] w_ptr_next;

    // Output stage can take a word when empty or draining this cycle
    assign w_load = ~r_y_valid | i_y_ready;

    // Fixed mode: an out-of-range selector matches no channel and so never grants
    always_comb begin
        w_fix_valid = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (i_selector == SEL_W'(j)) begin
                w_fix_valid = i_in_valid[j];
            end
        end
    end

    // Round-robin: scan ptr, ptr+1, ... modulo CHANNELS; descending loop lets the first hit win
    always_comb begin
        logic [SEL_W:0] idx;
        w_rr_gnt   = '0;
        w_rr_valid = |i_in_valid;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = {1'b0, r_ptr} + (SEL_W+1)'(k);
            if (idx >= (SEL_W+1)'(CHANNELS)) begin
                idx = idx - (SEL_W+1)'(CHANNELS);
            end
            for (int j = 0; j < CHANNELS; j++) begin
                if ((idx == (SEL_W+1)'(j)) && i_in_valid[j]) begin
                    w_rr_gnt = SEL_W'(j);
                end
            end
        end
    end

    assign w_gnt       = i_mode ? w_rr_gnt : i_selector;
    assign w_gnt_valid = i_mode ? w_rr_valid : w_fix_valid;
    assign w_xfer      = w_load & w_gnt_valid & ~i_reset;

    // Data mux and one-hot ready for the granted channel
    always_comb begin
        w_gnt_data = '0;
        o_in_ready = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (w_gnt == SEL_W'(j)) begin
                w_gnt_data    = i_in[j*WIDTH +: WIDTH];
                o_in_ready[j] = w_xfer;
            end
        end
    end

    assign w_ptr_next = (w_gnt == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt + SEL_W'(1);

    // Output register stage and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_y_channel <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_y         <= w_gnt_data;
            r_y_channel <= w_gnt;
            r_y_valid   <= 1'b1;
            if (i_mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (i_y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign o_y         = r_y;
    assign o_y_valid   = r_y_valid;
    assign o_y_channel = r_y_channel;

`ifdef MUX_STATS_EN
    logic [15:0] r_transfer_count;

    // Saturating count of accepted words
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_transfer_count <= '0;
        end else if (w_xfer && (r_transfer_count != 16'hFFFF)) begin
            r_transfer_count <= r_transfer_count + 16'd1;
        end
    end

    assign o_transfer_count = r_transfer_count;
`endif

endmodule

// File: tb/tb_mux_rr_sel.sv
// tb/tb_mux_rr_sel.sv - directed self-checking bench for mux_rr_sel
module tb_mux_rr_sel;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  selector;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  y_channel;
`ifdef MUX_STATS_EN
    logic [15:0] transfer_count;
`endif

    int checks = 0;
    int errors = 0;

    mux_rr_sel #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in        (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_mode      (mode),
        .i_selector  (selector),
        .o_y         (y),
        .o_y_valid   (y_valid),
        .i_y_ready   (y_ready),
        .o_y_channel (y_channel)
`ifdef MUX_STATS_EN
        ,
        .o_transfer_count (transfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_valid = 4'b1111;
        mode     = 1'b1;
        selector = 2'd1;
        y_ready  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0000", in_ready);
        end
        step();
        step();
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready2 got %b want 0000", in_ready);
        end
        checks++;
        if (y !== 8'h00 || y_valid !== 1'b0 || y_channel !== 2'd0) begin
            errors++;
            $display("FAIL reset_out got y=%h v=%b ch=%0d want y=00 v=0 ch=0", y, y_valid, y_channel);
        end
        in_valid = 4'b0000;
        reset    = 1'b0;
        step();
    endtask

    task automatic test_fixed();
        mode     = 1'b0;
        selector = 2'd2;
        y_ready  = 1'b1;
        in_data  = 32'h00A50000;
        in_valid = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready got %b want 0100", in_ready);
        end
        step();
        checks++;
        if (y !== 8'hA5 || y_valid !== 1'b1 || y_channel !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out got y=%h v=%b ch=%0d want y=a5 v=1 ch=2", y, y_valid, y_channel);
        end
        selector = 2'd3;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL fixed_nogrant_ready got %b want 0000", in_ready);
        end
        step();
        checks++;
        if (y_valid !== 1'b0 || y !== 8'hA5 || y_channel !== 2'd2) begin
            errors++;
            $display("FAIL fixed_drain got y=%h v=%b ch=%0d want y=a5 v=0 ch=2", y, y_valid, y_channel);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_rr_fair();
        logic [7:0] exp_y  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode     = 1'b1;
        y_ready  = 1'b1;
        in_data  = 32'h13121110;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_ch[i])) begin
                errors++;
                $display("FAIL rr_fair_ready[%0d] got %b want %b", i, in_ready, 4'b0001 << exp_ch[i]);
            end
            step();
            checks++;
            if (y !== exp_y[i] || y_valid !== 1'b1 || y_channel !== exp_ch[i]) begin
                errors++;
                $display("FAIL rr_fair_out[%0d] got y=%h v=%b ch=%0d want y=%h v=1 ch=%0d",
                         i, y, y_valid, y_channel, exp_y[i], exp_ch[i]);
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [1:0] exp_ch [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
        logic [7:0] exp_y  [4] = '{8'h13, 8'h10, 8'h13, 8'h10};
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (y !== exp_y[i] || y_channel !== exp_ch[i] || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_skip[%0d] got y=%h v=%b ch=%0d want y=%h v=1 ch=%0d",
                         i, y, y_valid, y_channel, exp_y[i], exp_ch[i]);
            end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        y_ready  = 1'b0;
        in_data  = 32'h00221100;
        in_valid = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first_ready got %b want 0010", in_ready);
        end
        step();
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall_ready[%0d] got %b want 0000", i, in_ready);
            end
            step();
            checks++;
            if (y !== 8'h11 || y_valid !== 1'b1 || y_channel !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got y=%h v=%b ch=%0d want y=11 v=1 ch=1", i, y, y_valid, y_channel);
            end
        end
        y_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready got %b want 0100", in_ready);
        end
        step();
        checks++;
        if (y !== 8'h22 || y_valid !== 1'b1 || y_channel !== 2'd2) begin
            errors++;
            $display("FAIL bp_back_to_back got y=%h v=%b ch=%0d want y=22 v=1 ch=2", y, y_valid, y_channel);
        end
        in_valid = 4'b0000;
        step();
        checks++;
        if (y_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b want 0", y_valid);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        mode     = 1'b1;
        y_ready  = 1'b1;
        in_data  = 32'h13121110;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (y !== 8'h10 || y_valid !== 1'b1 || y_channel !== 2'd0) begin
            errors++;
            $display("FAIL mid_pre got y=%h v=%b ch=%0d want y=10 v=1 ch=0", y, y_valid, y_channel);
        end
`ifdef MUX_STATS_EN
        checks++;
        if (transfer_count !== 16'd5) begin
            errors++;
            $display("FAIL stats_count got %0d want 5", transfer_count);
        end
`endif
        reset = 1'b1;
        step();
        checks++;
        if (y_valid !== 1'b0 || y !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset got y=%h v=%b want y=00 v=0", y, y_valid);
        end
`ifdef MUX_STATS_EN
        checks++;
        if (transfer_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear got %0d want 0", transfer_count);
        end
`endif
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr_ready got %b want 0001", in_ready);
        end
        step();
        checks++;
        if (y !== 8'h10 || y_channel !== 2'd0 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_ptr_out got y=%h v=%b ch=%0d want y=10 v=1 ch=0", y, y_valid, y_channel);
        end
        in_valid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_skip();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
